// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and sequencer state encoding for the ALU command sequencer.
package alu_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned CNT_W   = 16;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 4'd5;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd6;
    localparam logic [OP_W-1:0] OP_NAND = 4'd7;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd8;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd9;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd10;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd11;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd12;
    localparam logic [OP_W-1:0] OP_SEQ  = 4'd13;
    localparam logic [OP_W-1:0] OP_SNE  = 4'd14;
    localparam logic [OP_W-1:0] OP_RSVD = 4'd15;

    localparam int unsigned CF = 3;
    localparam int unsigned NF = 2;
    localparam int unsigned VF = 1;
    localparam int unsigned ZF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_32.sv
// Combinational ALU: result plus {cout, neg, overflow, zero}; the adder runs for every opcode.
module alu_32
    import alu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic [OP_W-1:0]   op,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    output logic [W-1:0]      y_c,
    output logic [FLAG_W-1:0] flags_c
);

    logic               is_sub;
    logic [W-1:0]       b_eff;
    logic [W:0]         sum;
    logic [SHAMT_W-1:0] shamt;
    logic               ovf;

    always_comb begin
        is_sub = (op == OP_SUB);
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + (W+1)'(is_sub);
        shamt  = b[SHAMT_W-1:0];
        // Signed overflow of a + b_eff (+1): same input signs, different result sign.
        ovf    = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);

        y_c = '0;
        case (op)
            OP_ADD, OP_SUB: y_c = sum[W-1:0];
            OP_AND:         y_c = a & b;
            OP_OR:          y_c = a | b;
            OP_XOR:         y_c = a ^ b;
            OP_XNOR:        y_c = ~(a ^ b);
            OP_NOR:         y_c = ~(a | b);
            OP_NAND:        y_c = ~(a & b);
            OP_SLL:         y_c = a << shamt;
            OP_SRL:         y_c = a >> shamt;
            OP_SRA:         y_c = $unsigned($signed(a) >>> shamt);
            OP_SLT:         y_c = W'($signed(a) < $signed(b));
            OP_SLTU:        y_c = W'(a < b);
            OP_SEQ:         y_c = W'(a == b);
            OP_SNE:         y_c = W'(a != b);
            default:        y_c = '0;
        endcase

        flags_c = '0;
        if (op == OP_RSVD) begin
            flags_c[ZF] = 1'b1;
        end else begin
            flags_c[CF] = sum[W];
            flags_c[NF] = y_c[W-1];
            flags_c[VF] = (op == OP_ADD || op == OP_SUB) && ovf;
            flags_c[ZF] = (y_c == '0);
        end
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Command sequencer: accept one ALU command, execute from a flop register file, write back, respond.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int unsigned W    = 32,
    parameter int unsigned NREG = 8,
    localparam int unsigned IW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [IW-1:0]     cmd_rd,
    input  logic [IW-1:0]     cmd_rs1,
    input  logic [IW-1:0]     cmd_rs2,
    input  logic              cmd_use_imm,
    input  logic [W-1:0]      cmd_imm,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic [IW-1:0]     rsp_rd,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  cmd_count
);

    logic [1:0]        rst_sync_q;
    logic              rst_sync_n;
    state_e            state_q, state_d;
    logic              accept_c;
    logic              wb_en_c;
    logic [OP_W-1:0]   op_q;
    logic [IW-1:0]     rd_q;
    logic              err_q;
    logic [W-1:0]      a_q, b_q;
    logic [W-1:0]      rs1_val_c, rs2_val_c;
    logic [W-1:0]      alu_y_c;
    logic [FLAG_W-1:0] alu_flags_c;
    logic [W-1:0]      regs_q [NREG];

    // Assert asynchronously, release two clock edges after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_sync_n = rst_sync_q[1];

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                accept_c = 1'b1;
                state_d  = EXEC;
            end
            EXEC: state_d = RESP;
            RESP: if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = rst_sync_n && (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);

    assign rs1_val_c = (cmd_rs1 == '0) ? '0 : regs_q[cmd_rs1];
    assign rs2_val_c = (cmd_rs2 == '0) ? '0 : regs_q[cmd_rs2];
    assign wb_en_c   = (state_q == EXEC) && !err_q && (rd_q != '0);

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wb_en_c) begin
            regs_q[rd_q] <= alu_y_c;
        end
    end

    // Operands are captured at accept so EXEC never sees later register updates.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            op_q  <= '0;
            rd_q  <= '0;
            err_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (accept_c) begin
            op_q  <= cmd_op;
            rd_q  <= cmd_rd;
            err_q <= (cmd_op == OP_RSVD);
            a_q   <= rs1_val_c;
            b_q   <= cmd_use_imm ? cmd_imm : rs2_val_c;
        end
    end

    alu_32 #(.W(W)) u_alu (
        .op      (op_q),
        .a       (a_q),
        .b       (b_q),
        .y_c     (alu_y_c),
        .flags_c (alu_flags_c)
    );

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_rd    <= '0;
            rsp_err   <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_data  <= alu_y_c;
            rsp_flags <= alu_flags_c;
            rsp_rd    <= rd_q;
            rsp_err   <= err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n)                       cmd_count <= '0;
        else if (accept_c && cmd_count != '1)  cmd_count <= cmd_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: directed vector table, multi-cycle corner sequences, random commands vs a reference model.
module tb_alu_cmd_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic        cmd_use_imm;
    logic [31:0] cmd_imm;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic [2:0]  rsp_rd;
    logic        rsp_err;
    logic [15:0] cmd_count;

    int tests = 0;
    int fails = 0;
    logic [31:0] mreg [8];
    int exp_count = 0;

    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -64'sh80000000;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rd, rs1, rs2;
        logic        ui;
        logic [31:0] imm;
        logic [31:0] exp_data;
        logic [3:0]  exp_flags;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    alu_cmd_seq #(.W(32), .NREG(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rs1     (cmd_rs1),
        .cmd_rs2     (cmd_rs2),
        .cmd_use_imm (cmd_use_imm),
        .cmd_imm     (cmd_imm),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_flags   (rsp_flags),
        .rsp_rd      (rsp_rd),
        .rsp_err     (rsp_err),
        .cmd_count   (cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                input logic [2:0] rs2, input logic ui, input logic [31:0] imm,
                                input logic [31:0] d, input logic [3:0] f, input logic e);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.ui = ui; v.imm = imm;
        v.exp_data = d; v.exp_flags = f; v.exp_err = e;
        return v;
    endfunction

    // Reference ALU from the opcode definitions, using 64-bit arithmetic for carry and overflow.
    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] y, output logic [3:0] f);
        longint unsigned ua, ub;
        longint sa, sb, s;
        int sh;
        logic cout, ovf;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        cout = (op == 4'd1) ? (ua >= ub) : ((ua + ub) > 64'hFFFF_FFFF);
        ovf = 1'b0;
        case (op)
            4'd0: begin y = 32'(ua + ub); s = sa + sb; ovf = (s > SMAX) || (s < SMIN); end
            4'd1: begin y = 32'(ua - ub); s = sa - sb; ovf = (s > SMAX) || (s < SMIN); end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            4'd5: y = ~(a ^ b);
            4'd6: y = ~(a | b);
            4'd7: y = ~(a & b);
            4'd8: y = a << sh;
            4'd9: y = a >> sh;
            4'd10: y = 32'(sa >>> sh);
            4'd11: y = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: y = (ua < ub) ? 32'd1 : 32'd0;
            4'd13: y = (a == b) ? 32'd1 : 32'd0;
            4'd14: y = (a != b) ? 32'd1 : 32'd0;
            default: y = 32'd0;
        endcase
        if (op == 4'd15) f = 4'b0001;
        else             f = {cout, y[31], ovf, (y == 32'd0)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mreg[i] = 32'd0;
        exp_count = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_use_imm = 1'b0; cmd_imm = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
    endtask

    // One full command; hold = cycles rsp_ready stays low once the response is up.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic ui, input logic [31:0] imm, input int hold,
                         output logic [31:0] d, output logic [3:0] f, output logic [2:0] r,
                         output logic e, output bit ok);
        int n;
        ok = 1'b0; d = '0; f = '0; r = '0; e = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_use_imm = ui; cmd_imm = imm;
        n = 0;
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        if (!cmd_ready) begin
            chk("accept timeout", 64'(cmd_ready), 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        exp_count++;
        n = 0;
        while (!rsp_valid && n < 10) begin @(negedge clk); n++; end
        chk("rsp latency", 64'(n), 64'd1);
        if (!rsp_valid) return;
        repeat (hold) @(negedge clk);
        d = rsp_data; f = rsp_flags; r = rsp_rd; e = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ok = 1'b1;
    endtask

    initial begin
        logic [31:0] d, a, b, ey;
        logic [3:0]  f, ef;
        logic [2:0]  r;
        logic        e;
        bit          ok;
        int          nr, nv;
        logic [3:0]  rop;
        logic [2:0]  rrd, rs1, rs2;
        logic        rui;
        logic [31:0] rimm;

        vecs[0]  = mk(4'd0,  3'd1, 3'd0, 3'd0, 1'b1, 32'd5,          32'd5,          4'b0000, 1'b0);
        vecs[1]  = mk(4'd0,  3'd2, 3'd1, 3'd0, 1'b1, 32'd7,          32'd12,         4'b0000, 1'b0);
        vecs[2]  = mk(4'd0,  3'd1, 3'd0, 3'd0, 1'b1, 32'h7FFFFFFF,   32'h7FFFFFFF,   4'b0000, 1'b0);
        vecs[3]  = mk(4'd0,  3'd3, 3'd1, 3'd0, 1'b1, 32'd1,          32'h80000000,   4'b0110, 1'b0);
        vecs[4]  = mk(4'd10, 3'd4, 3'd3, 3'd0, 1'b1, 32'd4,          32'hF8000000,   4'b0100, 1'b0);
        vecs[5]  = mk(4'd9,  3'd5, 3'd3, 3'd0, 1'b1, 32'd4,          32'h08000000,   4'b0000, 1'b0);
        vecs[6]  = mk(4'd15, 3'd3, 3'd1, 3'd0, 1'b1, 32'd0,          32'd0,          4'b0001, 1'b1);
        vecs[7]  = mk(4'd0,  3'd0, 3'd0, 3'd0, 1'b1, 32'd9,          32'd9,          4'b0000, 1'b0);
        vecs[8]  = mk(4'd0,  3'd6, 3'd3, 3'd0, 1'b0, 32'd0,          32'h80000000,   4'b0100, 1'b0);
        vecs[9]  = mk(4'd1,  3'd7, 3'd2, 3'd0, 1'b1, 32'd12,         32'd0,          4'b1001, 1'b0);
        vecs[10] = mk(4'd0,  3'd6, 3'd3, 3'd3, 1'b0, 32'd0,          32'd0,          4'b1011, 1'b0);
        vecs[11] = mk(4'd3,  3'd5, 3'd2, 3'd0, 1'b1, 32'hF0,         32'hFC,         4'b0000, 1'b0);
        vecs[12] = mk(4'd11, 3'd5, 3'd3, 3'd0, 1'b1, 32'd1,          32'd1,          4'b0000, 1'b0);
        vecs[13] = mk(4'd12, 3'd5, 3'd3, 3'd0, 1'b1, 32'd1,          32'd0,          4'b0001, 1'b0);
        vecs[14] = mk(4'd13, 3'd5, 3'd2, 3'd0, 1'b1, 32'd12,         32'd1,          4'b0000, 1'b0);
        vecs[15] = mk(4'd8,  3'd5, 3'd2, 3'd0, 1'b1, 32'h22,         32'h30,         4'b0000, 1'b0);

        rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_use_imm = 1'b0; cmd_imm = '0;
        @(negedge clk);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_data",  64'(rsp_data),  64'd0);
        chk("reset rsp_flags", 64'(rsp_flags), 64'd0);
        chk("reset rsp_rd",    64'(rsp_rd),    64'd0);
        chk("reset rsp_err",   64'(rsp_err),   64'd0);
        chk("reset cmd_count", 64'(cmd_count), 64'd0);
        do_reset();
        chk("post-reset cmd_ready", 64'(cmd_ready), 64'd1);

        // Directed table; rows depend on register state left by earlier rows.
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].ui, vecs[i].imm, 0, d, f, r, e, ok);
            if (ok) begin
                chk($sformatf("vec%0d data", i),  64'(d), 64'(vecs[i].exp_data));
                chk($sformatf("vec%0d flags", i), 64'(f), 64'(vecs[i].exp_flags));
                chk($sformatf("vec%0d rd", i),    64'(r), 64'(vecs[i].rd));
                chk($sformatf("vec%0d err", i),   64'(e), 64'(vecs[i].exp_err));
            end
            if (vecs[i].op != 4'd15 && vecs[i].rd != 3'd0) mreg[vecs[i].rd] = vecs[i].exp_data;
        end

        // Backpressure: response held 5 cycles with a competing command offered.
        ref_alu(4'd4, mreg[2], 32'hFF, ey, ef);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd4; cmd_rd = 3'd5; cmd_rs1 = 3'd2; cmd_use_imm = 1'b1; cmd_imm = 32'hFF;
        nr = 0;
        while (!cmd_ready && nr < 20) begin @(negedge clk); nr++; end
        chk("bp accept", 64'(cmd_ready), 64'd1);
        @(negedge clk);
        exp_count++;
        cmd_op = 4'd0; cmd_rd = 3'd6; cmd_imm = 32'd99;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d rsp_valid", i), 64'(rsp_valid), 64'd1);
            chk($sformatf("bp%0d cmd_ready", i), 64'(cmd_ready), 64'd0);
            chk($sformatf("bp%0d data", i),      64'(rsp_data),  64'(ey));
            chk($sformatf("bp%0d flags", i),     64'(rsp_flags), 64'(ef));
            chk($sformatf("bp%0d rd", i),        64'(rsp_rd),    64'd5);
            chk($sformatf("bp%0d count", i),     64'(cmd_count), 64'(exp_count));
            @(negedge clk);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp released rsp_valid", 64'(rsp_valid), 64'd0);
        chk("bp released cmd_ready", 64'(cmd_ready), 64'd1);
        mreg[5] = ey;

        // Peak throughput: valid and ready held high for 12 cycles.
        cmd_op = 4'd0; cmd_rd = 3'd0; cmd_rs1 = 3'd0; cmd_use_imm = 1'b1; cmd_imm = 32'd1;
        cmd_valid = 1'b1; rsp_ready = 1'b1;
        nr = 0; nv = 0;
        for (int i = 0; i < 12; i++) begin
            if (cmd_ready) nr++;
            if (rsp_valid) nv++;
            @(negedge clk);
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        exp_count += 4;
        chk("throughput accepts",   64'(nr), 64'd4);
        chk("throughput responses", 64'(nv), 64'd4);
        chk("throughput count",     64'(cmd_count), 64'(exp_count));

        // Random commands against the reference model.
        for (int i = 0; i < 60; i++) begin
            rop  = 4'($urandom_range(0, 15));
            rrd  = 3'($urandom_range(0, 7));
            rs1  = 3'($urandom_range(0, 7));
            rs2  = 3'($urandom_range(0, 7));
            rui  = 1'($urandom_range(0, 1));
            rimm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            a = mreg[rs1];
            b = rui ? rimm : mreg[rs2];
            ref_alu(rop, a, b, ey, ef);
            issue(rop, rrd, rs1, rs2, rui, rimm, $urandom_range(0, 2), d, f, r, e, ok);
            if (ok) begin
                chk($sformatf("rnd%0d op%0d data", i, rop),  64'(d), 64'(ey));
                chk($sformatf("rnd%0d op%0d flags", i, rop), 64'(f), 64'(ef));
                chk($sformatf("rnd%0d rd", i),               64'(r), 64'(rrd));
                chk($sformatf("rnd%0d err", i),              64'(e), 64'(rop == 4'd15));
            end
            if (rop != 4'd15 && rrd != 3'd0) mreg[rrd] = ey;
        end

        for (int i = 0; i < 8; i++) begin
            issue(4'd3, 3'd0, 3'(i), 3'd0, 1'b1, 32'd0, 0, d, f, r, e, ok);
            if (ok) chk($sformatf("readback reg%0d", i), 64'(d), 64'(mreg[i]));
        end
        chk("final cmd_count", 64'(cmd_count), 64'(exp_count));

        // Reset during EXEC aborts the command and clears everything.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_rd = 3'd4; cmd_rs1 = 3'd0; cmd_use_imm = 1'b1; cmd_imm = 32'd3;
        nr = 0;
        while (!cmd_ready && nr < 20) begin @(negedge clk); nr++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort rsp_valid",  64'(rsp_valid), 64'd0);
        chk("abort cmd_count",  64'(cmd_count), 64'd0);
        repeat (2) @(negedge clk);
        chk("abort held rsp_valid", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        chk("abort rsp_valid after release", 64'(rsp_valid), 64'd0);
        chk("abort cmd_count after release", 64'(cmd_count), 64'd0);
        issue(4'd0, 3'd0, 3'd4, 3'd0, 1'b1, 32'd0, 0, d, f, r, e, ok);
        if (ok) chk("abort reg4", 64'(d), 64'd0);
        chk("abort count after one cmd", 64'(cmd_count), 64'(exp_count));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_seq.md
ALU_CMD_SEQ -- requirements
Module: alu_cmd_seq

Interface
REQ-001 SHALL have parameter W, default 32, datapath width.
REQ-002 SHALL have parameter NREG, default 8, register-file depth; index width log2(NREG)=3.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_op  input  4  ALU operation code: 0 add, 1 sub, 2 AND, 3 OR, 4 XOR, 5 XNOR, 6 NOR, 7 NAND, 8 SLL, 9 SRL, 10 SRA, 11 SLT, 12 SLTU, 13 SEQ, 14 SNE, 15 reserved.
REQ-008 cmd_rd, cmd_rs1, cmd_rs2  input  3 each  destination and source register indices.
REQ-009 cmd_use_imm  input  1  when 1, operand B is cmd_imm instead of reg[rs2].
REQ-010 cmd_imm  input  W  immediate operand.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  consumer accepts response.
REQ-013 rsp_data  output  W  ALU result.
REQ-014 rsp_flags  output  4  {cout, neg, overflow, zero}.
REQ-015 rsp_rd  output  3  destination index of the responding command.
REQ-016 rsp_err  output  1  command used reserved opcode 15.
REQ-017 cmd_count  output  16  accepted-command counter.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, RESP; cmd_ready=1 only in IDLE, rsp_valid=1 only in RESP.
REQ-019 Handshake on cmd_valid&&cmd_ready at edge k SHALL latch op, rd, err, A=reg[rs1], B=(use_imm?imm:reg[rs2]) and move IDLE->EXEC.
REQ-020 In EXEC, latched op/A/B SHALL drive the ALU; at edge k+1 result and flags are registered into rsp_data/rsp_flags, state -> RESP.
REQ-021 Writeback of the result into reg[rd] SHALL occur at edge k+1, except when rd=0 or op=15.
REQ-022 reg[0] SHALL read as 0 always; writes to it are discarded.
REQ-023 Op 15 SHALL yield rsp_data=0, rsp_flags={0,0,0,1}, rsp_err=1.
REQ-024 Overflow flag SHALL be 0 for all ops other than 0 and 1; cout reports the adder carry for every op.
REQ-025 Shifts SHALL use B[4:0] only; SRA sign-extends A.
REQ-026 rsp_* SHALL hold stable while rsp_valid=1 and rsp_ready=0; RESP->IDLE on rsp_valid&&rsp_ready.
REQ-027 Peak throughput SHALL be one command per 3 cycles (rsp_ready held 1); rsp_valid rises 1 cycle after accept.
REQ-028 A command accepted in the cycle after a response SHALL read the updated register value (no hazard window, writeback precedes next accept).
REQ-029 cmd_count SHALL increment on each accept and saturate at 16'hFFFF.
REQ-030 cmd_valid in EXEC/RESP SHALL be ignored (not accepted, not counted).

Reset
REQ-031 On rst_n=0, immediately: state=IDLE, cmd_ready=1 (after first observation), rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_rd=0, rsp_err=0, cmd_count=0, all registers=0.
REQ-032 Reset asserted in EXEC or RESP SHALL abort the command: no writeback, no response, count retains nothing (cleared).
REQ-033 Deassertion SHALL be synchronized so the FSM leaves reset cleanly on a clk edge.

Structure
REQ-034 Package alu_pkg SHALL hold opcode constants, flag bit positions (CF=3, NF=2, VF=1, ZF=0), and the FSM state enum.
REQ-035 Datapath SHALL instantiate the existing alu_32 block as its single sub-module; no duplicated ALU logic.
REQ-036 Register file SHALL be flops, one write port, two combinational read ports.

Verification
REQ-037 Reset then cmd op=0, rs1=0, imm=5, use_imm, rd=1; then op=0, rs1=1, imm=7, rd=2 -> rsp_data 5 then 12; reg[2]=12.
REQ-038 reg1=32'h7FFFFFFF, op=0, imm=1 -> rsp_data=32'h80000000, flags overflow=1, neg=1, zero=0.
REQ-039 reg1=32'h80000000, op=10, imm=4 -> rsp_data=32'hF8000000; op=9 same -> 32'h08000000, overflow=0.
REQ-040 op=15, rd=3 -> rsp_err=1, rsp_data=0, zero=1, reg[3] unchanged; rd=0 write of 9 -> reg[0] still reads 0.
REQ-041 Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp_* stable, cmd_ready=0, cmd_count unchanged until release.
REQ-042 Assert rst_n=0 during EXEC of op=0 rd=4 imm=3 -> no rsp_valid, reg[4]=0, cmd_count=0.
